// File: rtl/pool2d_stream.sv
// Streaming 2D pooling engine: latches one feature map on start, walks every window
// one tap per cycle, and emits average or signed-max results on a valid/ready stream.
module pool2d_stream #(
  parameter int CH     = 1,
  parameter int IN_H   = 4,
  parameter int IN_W   = 4,
  parameter int K      = 2,
  parameter int STRIDE = 2,
  parameter int WIDTH  = 16,
  localparam int OUT_H = (IN_H - K) / STRIDE + 1,
  localparam int OUT_W = (IN_W - K) / STRIDE + 1,
  localparam int N_OUT = CH * OUT_H * OUT_W,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic [CH*IN_H*IN_W*WIDTH-1:0] in_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last
);

  localparam int KK        = K * K;
  localparam int ACC_WIDTH = WIDTH + $clog2(KK) + 1;
  localparam int N_IN      = CH * IN_H * IN_W;
  localparam int IN_IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KC_W      = (K > 1) ? $clog2(K) : 1;
  localparam int OW_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OH_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int C_W       = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [KC_W-1:0]      K_LAST   = KC_W'(K - 1);
  localparam logic [OW_W-1:0]      OW_LAST  = OW_W'(OUT_W - 1);
  localparam logic [OH_W-1:0]      OH_LAST  = OH_W'(OUT_H - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_OUT - 1);
  localparam logic [ACC_WIDTH-1:0] KK_DIV   = ACC_WIDTH'(KK);
  localparam logic [ACC_WIDTH-1:0] KK_HALF  = ACC_WIDTH'(KK / 2);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT} state_t;

  state_t                       r_state;
  logic                         r_busy, r_done, r_valid, r_last, r_mode;
  logic [WIDTH-1:0]             r_data;
  logic [IDX_W-1:0]             r_idx;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [KC_W-1:0]              r_kh, r_kw;
  logic [OW_W-1:0]              r_ow;
  logic [OH_W-1:0]              r_oh;
  logic [C_W-1:0]               r_c;
  logic [WIDTH-1:0]             r_mem [N_IN];

  logic                         w_accept;
  logic [IN_IDX_W-1:0]          w_tap_idx;
  logic signed [WIDTH-1:0]      w_tap;
  logic signed [ACC_WIDTH-1:0]  w_tap_ext, w_acc_next;
  logic                         w_neg;
  logic [ACC_WIDTH-1:0]         w_mag, w_quot, w_avg;
  logic [WIDTH-1:0]             w_result;

  assign w_accept = (r_state == S_IDLE) && start;

  // NOTE: the latched frame is pure storage with no reset; every start overwrites it before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < N_IN; i++) r_mem[i] <= in_vec[i*WIDTH +: WIDTH];
    end
  end

  assign w_tap_idx = IN_IDX_W'((32'(r_c) * IN_H + 32'(r_oh) * STRIDE + 32'(r_kh)) * IN_W
                               + 32'(r_ow) * STRIDE + 32'(r_kw));
  assign w_tap     = r_mem[w_tap_idx];
  assign w_tap_ext = w_tap;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_acc_next = r_acc;
    if (!r_mode) begin
      w_acc_next = r_acc + w_tap_ext;
    end else if (((r_kh == '0) && (r_kw == '0)) || (w_tap_ext > r_acc)) begin
      w_acc_next = w_tap_ext;
    end
  end

  // Round half away from zero by dividing the magnitude and restoring the sign.
  assign w_neg    = w_acc_next[ACC_WIDTH-1];
  assign w_mag    = w_neg ? -w_acc_next : w_acc_next;
  assign w_quot   = (w_mag + KK_HALF) / KK_DIV;
  assign w_avg    = w_neg ? -w_quot : w_quot;
  assign w_result = r_mode ? WIDTH'(w_acc_next) : WIDTH'(w_avg);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_mode  <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_kh    <= '0;
      r_kw    <= '0;
      r_ow    <= '0;
      r_oh    <= '0;
      r_c     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_acc   <= '0;
            r_kh    <= '0;
            r_kw    <= '0;
            r_ow    <= '0;
            r_oh    <= '0;
            r_c     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_kw == K_LAST) begin
            r_kw <= '0;
            if (r_kh == K_LAST) begin
              r_kh    <= '0;
              r_data  <= w_result;
              r_valid <= 1'b1;
              r_last  <= (r_idx == IDX_LAST);
              r_state <= S_EMIT;
            end else begin
              r_kh <= r_kh + KC_W'(1);
            end
          end else begin
            r_kw <= r_kw + KC_W'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_acc   <= '0;
              r_state <= S_ACC;
              if (r_ow == OW_LAST) begin
                r_ow <= '0;
                if (r_oh == OH_LAST) begin
                  r_oh <= '0;
                  r_c  <= r_c + C_W'(1);
                end else begin
                  r_oh <= r_oh + OH_W'(1);
                end
              end else begin
                r_ow <= r_ow + OW_W'(1);
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: a 2x2 single-window instance driven from a vector table,
// and a 2-channel 4x4 instance driven by directed and random frames against a window model.
module tb_pool2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_mode, a_busy, a_done, a_valid, a_ready, a_last;
  logic [63:0] a_in;
  logic [15:0] a_data;
  logic [0:0]  a_idx;

  logic         b_start, b_mode, b_busy, b_done, b_valid, b_ready, b_last;
  logic [511:0] b_in;
  logic [15:0]  b_data;
  logic [2:0]   b_idx;

  int n_checks = 0;
  int n_errors = 0;

  pool2d_stream #(.CH(1), .IN_H(2), .IN_W(2), .K(2), .STRIDE(2), .WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .in_vec(a_in),
    .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_data), .out_idx(a_idx), .out_last(a_last)
  );

  pool2d_stream #(.CH(2), .IN_H(4), .IN_W(4), .K(2), .STRIDE(2), .WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .in_vec(b_in),
    .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_idx(b_idx), .out_last(b_last)
  );

  typedef struct {
    logic [63:0] vin;
    logic        mode;
    int          exp;
  } a_vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // Reference: gather each window's taps and apply the pooling rule directly.
  function automatic void model_b(input logic [511:0] v, input logic m, output int e[8]);
    int k = 0;
    for (int c = 0; c < 2; c++)
      for (int oh = 0; oh < 2; oh++)
        for (int ow = 0; ow < 2; ow++) begin
          int s = 0;
          int mx = -2147483647;
          for (int kh = 0; kh < 2; kh++)
            for (int kw = 0; kw < 2; kw++) begin
              int t;
              t = $signed(v[((c*4 + oh*2 + kh)*4 + ow*2 + kw)*16 +: 16]);
              s += t;
              if (t > mx) mx = t;
            end
          if (m) e[k] = mx;
          else if (s >= 0) e[k] = (s + 2) / 4;
          else e[k] = -((-s + 2) / 4);
          k++;
        end
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 32; i++) begin
      logic [15:0] e;
      if ($urandom_range(0, 1) == 1) e = 16'($urandom);
      else e = 16'($urandom_range(0, 12)) - 16'd6;
      v[i*16 +: 16] = e;
    end
    return v;
  endfunction

  task automatic run_a(input logic [63:0] vin, input logic m, input int exp);
    int cyc;
    a_in = vin; a_mode = m; a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_in = ~vin; a_mode = ~m;
    check("a_busy", a_busy, 1);
    cyc = 0;
    while (!a_valid && cyc < 20) begin tick; cyc++; end
    check("a_latency", cyc, 4);
    check("a_data", $signed(a_data), exp);
    check("a_idx", a_idx, 0);
    check("a_last", a_last, 1);
    tick;
    check("a_done", a_done, 1);
    check("a_valid_off", a_valid, 0);
    check("a_busy_off", a_busy, 0);
    tick;
    check("a_done_pulse", a_done, 0);
  endtask

  task automatic start_b(input logic [511:0] v, input logic m);
    b_in = v; b_mode = m; b_start = 1'b1;
    tick;
    b_start = 1'b0;
  endtask

  // Collects n_take outputs; a partial collection stops with the last one still pending.
  task automatic collect_b(input int exp[8], input int n_take, input int stall_k,
                           input int stall_n, input bit rand_bp);
    for (int k = 0; k < n_take; k++) begin
      int cyc = 0;
      int stalls;
      while (!b_valid && cyc < 40) begin tick; cyc++; end
      check("b_valid_timeout", b_valid, 1);
      check("b_idx", b_idx, k);
      check("b_data", $signed(b_data), exp[k]);
      check("b_last", b_last, (k == 7) ? 1 : 0);
      if (n_take < 8 && k == n_take - 1) return;
      stalls = (k == stall_k) ? stall_n : (rand_bp ? int'($urandom_range(0, 3)) : 0);
      repeat (stalls) begin
        b_ready = 1'b0;
        tick;
        check("b_hold_valid", b_valid, 1);
        check("b_hold_idx", b_idx, k);
        check("b_hold_data", $signed(b_data), exp[k]);
      end
      b_ready = 1'b1;
      tick;
      b_ready = 1'b0;
      check("b_valid_drop", b_valid, 0);
    end
    check("b_done", b_done, 1);
    check("b_busy_end", b_busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_vec_t       a_tab[14];
    logic [511:0] v, v2;
    int           e[8], e2[8];
    int           flat_max[8];

    a_tab[0]  = '{pack4(1, 2, 3, 4), 1'b0, 3};
    a_tab[1]  = '{pack4(-1, -2, -3, -4), 1'b0, -3};
    a_tab[2]  = '{pack4(-1, 0, 0, 0), 1'b0, 0};
    a_tab[3]  = '{pack4(-5, -2, -7, -3), 1'b1, -2};
    a_tab[4]  = '{pack4(1, 1, 0, 0), 1'b0, 1};
    a_tab[5]  = '{pack4(-1, -1, 0, 0), 1'b0, -1};
    a_tab[6]  = '{pack4(32767, 32767, 32767, 32767), 1'b0, 32767};
    a_tab[7]  = '{pack4(-32768, -32768, -32768, -32768), 1'b0, -32768};
    a_tab[8]  = '{pack4(5, 9, 9, 1), 1'b1, 9};
    a_tab[9]  = '{pack4(0, 0, 0, 1), 1'b1, 1};
    a_tab[10] = '{pack4(-2, 0, 0, 0), 1'b0, -1};
    a_tab[11] = '{pack4(3, 0, 0, 0), 1'b0, 1};
    a_tab[12] = '{pack4(-32768, 32767, -32768, 32767), 1'b1, 32767};
    a_tab[13] = '{pack4(1, 0, 0, 0), 1'b0, 0};
    flat_max = '{5, 7, 13, 15, 21, 23, 29, 31};

    rst = 1'b1;
    a_start = 1'b0; a_mode = 1'b0; a_in = '0; a_ready = 1'b1;
    b_start = 1'b0; b_mode = 1'b0; b_in = '0; b_ready = 1'b0;
    tick;
    tick;
    check("rst_a_busy", a_busy, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_done", b_done, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_last", b_last, 0);
    check("rst_b_data", b_data, 0);
    check("rst_b_idx", b_idx, 0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 14; i++) run_a(a_tab[i].vin, a_tab[i].mode, a_tab[i].exp);

    // Flat-index max frame with a 6-cycle stall on output 1.
    for (int i = 0; i < 32; i++) v[i*16 +: 16] = 16'(i);
    start_b(v, 1'b1);
    check("b_busy_start", b_busy, 1);
    collect_b(flat_max, 8, 1, 6, 1'b0);
    tick;
    check("b_done_pulse", b_done, 0);

    // A start mid-frame with different data must be ignored.
    v = rand_vec();
    model_b(v, 1'b0, e);
    start_b(v, 1'b0);
    tick;
    tick;
    b_in = rand_vec(); b_mode = 1'b1; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    collect_b(e, 8, -1, 0, 1'b1);

    // A start during the done cycle begins the next frame.
    v2 = rand_vec();
    model_b(v2, 1'b1, e2);
    b_in = v2; b_mode = 1'b1; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    check("b_busy_restart", b_busy, 1);
    collect_b(e2, 8, -1, 0, 1'b0);
    tick;
    check("b_done_pulse2", b_done, 0);

    // Reset while output 2 is pending discards the frame.
    v = rand_vec();
    model_b(v, 1'b0, e);
    start_b(v, 1'b0);
    collect_b(e, 3, -1, 0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("b_rst_valid", b_valid, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_last", b_last, 0);
    check("b_rst_done", b_done, 0);
    repeat (6) begin
      tick;
      check("b_rst_no_done", b_done, 0);
      check("b_rst_no_valid", b_valid, 0);
    end
    v = rand_vec();
    model_b(v, 1'b1, e);
    start_b(v, 1'b1);
    collect_b(e, 8, -1, 0, 1'b0);
    tick;

    for (int f = 0; f < 8; f++) begin
      logic m;
      v = rand_vec();
      m = 1'($urandom_range(0, 1));
      model_b(v, m, e);
      start_b(v, m);
      collect_b(e, 8, -1, 0, 1'b1);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Sequential, parametrised successor to the combinational 2D average pool.
- Latches one flattened multi-channel feature map on a start handshake, then iterates over every pooling window, one tap per cycle.
- Emits one pooled element at a time on a valid/ready output stream with backpressure.
- Runtime mode selects average (round-half-away-from-zero) or signed max pooling; sits between conv/activation stages and the next layer's input buffer.

Parameters:
- CH, 1, number of channels
- IN_H, 4, input height
- IN_W, 4, input width
- K, 2, square window size (K>=1)
- STRIDE, 2, window stride (STRIDE>=1)
- WIDTH, 16, signed element width (Q8.8 fixed point by default; arithmetic is on raw integers)
- Derived: OUT_H=(IN_H-K)/STRIDE+1, OUT_W=(IN_W-K)/STRIDE+1, N_OUT=CH*OUT_H*OUT_W, ACC_WIDTH=WIDTH+$clog2(K*K)+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to latch in_vec/mode and begin a frame
- mode  in  1  0 = average, 1 = max; sampled with start
- in_vec  in  CH*IN_H*IN_W*WIDTH  flattened input; element (c,h,w) at index ((c*IN_H+h)*IN_W+w)*WIDTH
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after the last output handshake
- out_valid  out  1  out_data holds a valid pooled element
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  WIDTH  signed pooled element
- out_idx  out  $clog2(N_OUT) (min 1)  flat output index ((c*OUT_H+oh)*OUT_W+ow)
- out_last  out  1  high with out_valid on the final element of the frame

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at a clk edge): state=IDLE; busy, done, out_valid, out_last=0; out_data, out_idx=0; counters cleared. Applies mid-frame: the frame is discarded, no done pulse, and the next start begins fresh.
- FSM states are IDLE, ACC, EMIT.
- IDLE: on start=1, latch in_vec and mode, zero all counters and the accumulator, busy<=1, go ACC. done=0 in all cycles except the one defined below.
- ACC: each cycle consumes tap (kh,kw) at input (c, oh*STRIDE+kh, ow*STRIDE+kw); kw is the inner counter, kh the outer.
  - avg mode: acc += sign-extended tap (ACC_WIDTH bits).
  - max mode: first tap loads acc; later taps update acc only if the tap is strictly greater (signed).
  - After the K*K-th tap, register the result into out_data, set out_valid=1 and out_idx, set out_last if the index is N_OUT-1, go EMIT.
- Average result: sum S over K*K taps. If S>=0, out=(S+K*K/2)/(K*K); if S<0, out=-((|S|+K*K/2)/(K*K)). Integer division truncates. Keep the low WIDTH bits; no saturation is needed because the magnitude cannot exceed the input range.
- Max result is the largest tap, exactly.
- EMIT: out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0. On out_valid & out_ready:
  - If the element was the last: out_valid<=0, out_last<=0, busy<=0, done<=1 for one cycle, go IDLE.
  - Otherwise: out_valid<=0, advance ow, then oh, then c (channel-major, row, column order); clear acc; go ACC.
- Latency: start accepted at edge T; first out_valid is visible after edge T+K*K. With out_ready held high, each output occupies K*K+1 cycles. Frame time is N_OUT*(K*K+1) cycles plus the done cycle.
- start while busy=1 is ignored, and in_vec/mode changes while busy have no effect.
- start in the same cycle as the done pulse is accepted, because the FSM is already in IDLE.
- The out_ready value is irrelevant when out_valid=0.
- K=1,STRIDE=1 degenerates to a pass-through, one element per 2 cycles.

Test Plan:
- CH=1, 2x2, K=2, S=2, avg mode, raw inputs {1,2,3,4}: one output, out_data=3 (10/4 rounds up), out_idx=0, out_last=1, then a done pulse. First out_valid at 4 cycles after start acceptance.
- Same config, avg mode, raw inputs {-1,-2,-3,-4}: out_data=-3. Raw inputs {-1,0,0,0}: out_data=0 (|-1|+2=3, 3/4=0). Max mode with {-5,-2,-7,-3}: out_data=-2.
- CH=2, 4x4, K=2, S=2, max mode, element value = flat input index: 8 outputs in order with out_idx 0..7; data 5,7,13,15,21,23,29,31; out_last only on idx 7.
- Backpressure: hold out_ready=0 for 6 cycles on output 1. out_valid stays 1, and out_data/out_idx are unchanged. No further outputs are produced until the handshake completes.
- Assert start (with different in_vec) mid-frame: ignored, and the outputs match the original frame. Assert start during the done cycle: a new frame starts and busy stays high.
- Assert rst during EMIT of output 2: next cycle out_valid=0, busy=0, no done pulse. A subsequent start produces a full correct frame from idx 0.
